// File: rtl/button_io_port.sv
// button_io_port: debounced push-button with pending/count registers on a 2-word memory-mapped window.
// Optional registered irq output enabled by defining BUTTON_IO_IRQ_EN.
module button_io_port #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        button,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_we,
  output logic [31:0] mem_rdata,
  output logic        hit,
  output logic        irq,
  output logic [3:0]  led_debug
);
  typedef enum logic [1:0] {RELEASED = 2'b00, PRESS_WAIT = 2'b01, PRESSED = 2'b10, RELEASE_WAIT = 2'b11} state_t;
  localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);
  state_t state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [7:0] count;
  logic s1, s2, sync_pressed, level, pending, press, clr_pend, clr_cnt, unused_bits;
  assign sync_pressed = ~s2;
  assign level = state[1];
  assign hit = mem_addr[31:3] == BASE_ADDR[31:3];
  assign clr_pend = hit & mem_we & ~mem_addr[2] & mem_wdata[1];
  assign clr_cnt = hit & mem_we & mem_addr[2];
  assign mem_rdata = !hit ? 32'd0 : mem_addr[2] ? {24'd0, count} : {30'd0, pending, level};
  assign led_debug = {state, pending, level};
  assign unused_bits = ^{mem_wdata[31:2], mem_wdata[0], mem_addr[1:0]};
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      state <= RELEASED;
      cnt <= 16'd0;
      pending <= 1'b0;
      count <= 8'd0;
    end else begin
      s1 <= button;
      s2 <= s1;
      state <= state_n;
      cnt <= cnt_n;
      pending <= press | (pending & ~clr_pend);
      count <= press ? (clr_cnt ? 8'd1 : count + 8'd1) : (clr_cnt ? 8'd0 : count);
    end
  end
  // The WAIT states count consecutive cycles of the new level; any reversal drops back to the stable state.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    press = 1'b0;
    case (state)
      RELEASED: if (sync_pressed) begin
        state_n = PRESS_WAIT;
        cnt_n = 16'd1;
      end
      PRESS_WAIT: if (!sync_pressed) begin
        state_n = RELEASED;
        cnt_n = 16'd0;
      end else if (cnt == LAST) begin
        state_n = PRESSED;
        cnt_n = 16'd0;
        press = 1'b1;
      end else cnt_n = cnt + 16'd1;
      PRESSED: if (!sync_pressed) begin
        state_n = RELEASE_WAIT;
        cnt_n = 16'd1;
      end
      RELEASE_WAIT: if (sync_pressed) begin
        state_n = PRESSED;
        cnt_n = 16'd0;
      end else if (cnt == LAST) begin
        state_n = RELEASED;
        cnt_n = 16'd0;
      end else cnt_n = cnt + 16'd1;
      default: state_n = RELEASED;
    endcase
  end
`ifdef BUTTON_IO_IRQ_EN
  always_ff @(posedge clk) irq <= reset ? 1'b0 : pending;
`else
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_button_io_port.sv
// tb_button_io_port: directed checks of debounce timing, glitch rejection, register access and reset for button_io_port.
module tb_button_io_port;
  localparam logic [31:0] BASE = 32'h0000_0400;
`ifdef BUTTON_IO_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, button = 1'b1, mem_we = 1'b0, hit, irq;
  logic [31:0] mem_addr = BASE, mem_wdata = 32'd0, mem_rdata;
  logic [3:0] led_debug;
  int checks = 0, failures = 0;
  button_io_port dut (
    .clk(clk), .reset(reset), .button(button), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .hit(hit), .irq(irq), .led_debug(led_debug)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    mem_addr = addr;
    #1;
    check(tag, mem_rdata, exp);
  endtask
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    mem_addr = addr;
    mem_wdata = data;
    mem_we = 1'b1;
    tick();
    mem_we = 1'b0;
    mem_addr = BASE;
  endtask
  task automatic press_release();
    button = 1'b0;
    tick(10);
    button = 1'b1;
    tick(8);
  endtask
  initial begin
    tick(3);
    reset = 1'b0;
    rd("rst_status", BASE, 32'h0);
    check("rst_hit", {31'd0, hit}, 32'd1);
    rd("rst_count", BASE + 4, 32'h0);
    check("rst_led", {28'd0, led_debug}, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    mem_addr = BASE + 8;
    #1;
    check("miss_hit", {31'd0, hit}, 32'd0);
    check("miss_rdata", mem_rdata, 32'h0);
    // single-cycle glitch
    button = 1'b0;
    tick();
    button = 1'b1;
    tick(2);
    check("glitch_wait_led", {28'd0, led_debug}, 32'h4);
    tick();
    check("glitch_back_led", {28'd0, led_debug}, 32'h0);
    tick(6);
    rd("glitch_status", BASE, 32'h0);
    rd("glitch_count", BASE + 4, 32'h0);
    // debounce latency: visible at edge 6 after the sampling edge
    button = 1'b0;
    tick(5);
    rd("press_e5_status", BASE, 32'h0);
    check("press_e5_led", {28'd0, led_debug}, 32'h4);
    check("press_e5_irq", {31'd0, irq}, 32'd0);
    tick();
    rd("press_e6_status", BASE, 32'h3);
    rd("press_e6_count", BASE + 4, 32'h1);
    check("press_e6_led", {28'd0, led_debug}, 32'hB);
    tick();
    check("press_irq", {31'd0, irq}, {31'd0, IRQ_ON});
    tick(3);
    button = 1'b1;
    tick(5);
    check("rel_e5_led", {28'd0, led_debug}, 32'hF);
    tick();
    check("rel_e6_led", {28'd0, led_debug}, 32'h2);
    rd("rel_status", BASE, 32'h2);
    // register writes
    wr(BASE, 32'h1);
    rd("wr_bit0_status", BASE, 32'h2);
    wr(BASE + 8, 32'h2);
    rd("wr_miss_status", BASE, 32'h2);
    wr(BASE + 12, 32'hFF);
    rd("wr_miss_count", BASE + 4, 32'h1);
    wr(BASE, 32'h2);
    rd("clr_status", BASE, 32'h0);
    rd("clr_keep_count", BASE + 4, 32'h1);
    tick();
    check("clr_irq", {31'd0, irq}, 32'd0);
    wr(BASE + 4, 32'h0);
    rd("clr_count", BASE + 4, 32'h0);
    // wrap 255 -> 0
    repeat (255) press_release();
    rd("count_255", BASE + 4, 32'hFF);
    press_release();
    rd("count_wrap", BASE + 4, 32'h0);
    rd("wrap_status", BASE, 32'h2);
    // press event coinciding with STATUS clear: set wins
    wr(BASE, 32'h2);
    rd("pre_coinc_status", BASE, 32'h0);
    button = 1'b0;
    tick(5);
    wr(BASE, 32'h2);
    rd("coinc_status", BASE, 32'h3);
    rd("coinc_count", BASE + 4, 32'h1);
    button = 1'b1;
    tick(8);
    // press event coinciding with COUNT clear: count ends at 1
    button = 1'b0;
    tick(5);
    wr(BASE + 4, 32'h0);
    rd("coinc_cnt_clr", BASE + 4, 32'h1);
    button = 1'b1;
    tick(8);
    rd("post_coinc_count", BASE + 4, 32'h1);
    // reset in PRESS_WAIT with counter=2
    button = 1'b0;
    tick(4);
    check("midbounce_led", {28'd0, led_debug}, 32'h6);
    reset = 1'b1;
    button = 1'b1;
    tick(2);
    reset = 1'b0;
    rd("mid_rst_status", BASE, 32'h0);
    rd("mid_rst_count", BASE + 4, 32'h0);
    check("mid_rst_led", {28'd0, led_debug}, 32'h0);
    tick(8);
    rd("mid_rst_later_count", BASE + 4, 32'h0);
    check("mid_rst_irq", {31'd0, irq}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/button_io_port.md
BUTTON_IO_PORT -- requirements
Module: button_io_port

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, cycles a synchronized level must stay stable before it is accepted (legal 2..65535).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0400, word-aligned base of the 2-word register window.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port button  input  1  raw asynchronous push-button, active-low (0 = pressed).
REQ-006 SHALL have port mem_addr  input  32  processor data address.
REQ-007 SHALL have port mem_wdata  input  32  processor write data.
REQ-008 SHALL have port mem_we  input  1  processor write strobe, sampled on clk.
REQ-009 SHALL have port mem_rdata  output  32  read data for addressed register, 0 when address outside window.
REQ-010 SHALL have port hit  output  1  high when mem_addr[31:3] equals BASE_ADDR[31:3].
REQ-011 SHALL have port irq  output  1  press-pending interrupt request.
REQ-012 SHALL have port led_debug  output  4  bit0 debounced level, bit1 pending, bits3:2 debounce FSM state code.

Function
REQ-013 SHALL pass button through a 2-flop synchronizer and invert it, giving sync_pressed (1 = pressed).
REQ-014 SHALL implement FSM RELEASED(00), PRESS_WAIT(01), PRESSED(10), RELEASE_WAIT(11) with a 16-bit stability counter.
REQ-015 RELEASED: sync_pressed=1 -> PRESS_WAIT, counter=1; otherwise stay.
REQ-016 PRESS_WAIT: sync_pressed=0 -> RELEASED, counter=0; counter=DEBOUNCE_CYCLES-1 with sync_pressed=1 -> PRESSED; else counter+1.
REQ-017 PRESSED and RELEASE_WAIT SHALL mirror REQ-015/016 with sync_pressed inverted, returning to RELEASED.
REQ-018 Debounced level SHALL be 1 in PRESSED and RELEASE_WAIT, 0 otherwise; a held raw press becomes visible exactly DEBOUNCE_CYCLES+2 rising edges after the sampled raw edge.
REQ-019 A single-cycle glitch on sync_pressed SHALL return the FSM to its stable state without changing the debounced level.
REQ-020 On the PRESS_WAIT->PRESSED transition the block SHALL set pending=1 and increment an 8-bit press count, wrapping 255 -> 0.
REQ-021 Register offset 0x0 (STATUS) SHALL read {30'b0, pending, debounced}; offset 0x4 (COUNT) SHALL read {24'b0, count}.
REQ-022 Reads SHALL be combinational from mem_addr with no wait states.
REQ-023 Write to STATUS with mem_wdata[1]=1 SHALL clear pending; write to COUNT SHALL clear count; all other write bits ignored.
REQ-024 Simultaneous press event and STATUS clear in the same cycle: pending SHALL end at 1 (set wins).
REQ-025 Simultaneous press event and COUNT clear in the same cycle: count SHALL end at 1.
REQ-026 Writes with hit=0 SHALL have no effect.

Reset
REQ-027 While reset=1 at a clock edge: FSM=RELEASED, counter=0, synchronizer flops=1 (released), pending=0, count=0.
REQ-028 After reset, outputs SHALL be irq=0, led_debug=4'b0000, mem_rdata=0 for STATUS and COUNT.
REQ-029 Reset asserted mid-debounce SHALL discard the partial count; no press is recorded.

Configuration
REQ-030 Macro BUTTON_IO_IRQ_EN defined: irq SHALL equal pending, registered, updating one cycle after pending changes.
REQ-031 Macro BUTTON_IO_IRQ_EN undefined: irq SHALL be tied to 0 and no irq flop SHALL be present; all other behaviour identical.

Verification
REQ-032 Reset 3 cycles, button=1 -> STATUS=0x0, COUNT=0x0, led_debug=0000, irq=0.
REQ-033 DEBOUNCE_CYCLES=4, button 1->0 held 10 cycles -> STATUS=0x3 at edge 6 after the sampled edge, COUNT=0x1, irq=1 one cycle later (IRQ build).
REQ-034 Button low for 1 cycle then high -> STATUS stays 0x0, COUNT stays 0x0, FSM back to RELEASED.
REQ-035 After one press, write 0x2 to BASE_ADDR -> STATUS bit1=0 next cycle, COUNT still 0x1; write to BASE_ADDR+4 -> COUNT=0x0.
REQ-036 Preload 255 presses then one more -> COUNT=0x00; press event coinciding with STATUS clear write -> pending=1.
REQ-037 Reset asserted during PRESS_WAIT (counter=2) -> after reset STATUS=0x0, COUNT=0x0, led_debug=0000.
